// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and result layout shared by the sequential ALU
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam int QUO_HALF = 0;
  localparam int REM_HALF = 1;
  typedef enum logic [2:0] {IDLE, EXEC, MUL_IT, DIV_IT, DIV_FIX, DONE_DIV0, DONE} state_t;
endpackage

// File: rtl/alu_shift_engine.sv
// alu_shift_engine: shared accumulator/shift register for Booth multiply and non-restoring divide
module alu_shift_engine #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               mul_step,
  input  logic               div_step,
  input  logic               fix,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q_init,
  output logic [2*WIDTH-1:0] prod
);
  logic [2*WIDTH:0] acc;
  logic             q_m1;
  logic [WIDTH:0]   hi, ms, mu, bsum, dsum;
  logic [WIDTH-1:0] lo;
  always_comb begin
    hi = acc[2*WIDTH:WIDTH];
    lo = acc[WIDTH-1:0];
    ms = {m[WIDTH-1], m};
    mu = {1'b0, m};
    bsum = ({lo[0], q_m1} == 2'b01) ? hi + ms : ({lo[0], q_m1} == 2'b10) ? hi - ms : hi;
    // the remainder is kept modulo 2^(WIDTH+1); its true value always fits after the add/sub
    dsum = {hi[WIDTH-1:0], lo[WIDTH-1]} + (hi[WIDTH] ? mu : -mu);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc  <= '0;
      q_m1 <= 1'b0;
    end else if (load) begin
      acc  <= {{(WIDTH+1){1'b0}}, q_init};
      q_m1 <= 1'b0;
    end else if (mul_step) begin
      acc  <= {bsum[WIDTH], bsum, lo[WIDTH-1:1]};
      q_m1 <= lo[0];
    end else if (div_step) begin
      acc <= {dsum, lo[WIDTH-2:0], ~dsum[WIDTH]};
    end else if (fix && hi[WIDTH]) begin
      acc[2*WIDTH:WIDTH] <= hi + mu;
    end
  end
  assign prod = acc[2*WIDTH-1:0];
endmodule

// File: rtl/alu_seq_param.sv
// alu_seq_param: multi-cycle WIDTH-bit ALU (add, sub, Booth mul, non-restoring div) with start/busy/done
module alu_seq_param import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op_code,
  input  logic [WIDTH-1:0]   operand_A,
  input  logic [WIDTH-1:0]   operand_B,
  output logic               busy,
  output logic               alu_done,
  output logic [2*WIDTH-1:0] alu_result,
  output logic               flag_carry,
  output logic               flag_overflow,
  output logic               flag_zero,
  output logic               flag_div0
);
  localparam int CW = $clog2(WIDTH+1);
  state_t             state, nxt;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a, b, bx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, res_n;
  logic [WIDTH:0]     sum, ptop;
  logic               accept, fin, mul_step, div_step, fix, sub, c_n, o_n;
  alu_shift_engine #(.WIDTH(WIDTH)) u_eng (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .mul_step(mul_step),
    .div_step(div_step),
    .fix(fix),
    .m(op == OP_MUL ? a : b),
    .q_init(op_code == OP_MUL ? operand_B : operand_A),
    .prod(prod)
  );
  always_comb begin
    accept = state == IDLE && start;
    fin = cnt == '0;
    mul_step = state == MUL_IT && !fin;
    div_step = state == DIV_IT && !fin;
    fix = state == DIV_IT && fin;
    nxt = state;
    case (state)
      IDLE:                     if (start) nxt = op_code == OP_MUL ? MUL_IT : op_code != OP_DIV ? EXEC : operand_B == '0 ? DONE_DIV0 : DIV_IT;
      EXEC, DIV_FIX, DONE_DIV0: nxt = DONE;
      MUL_IT:                   if (fin) nxt = DONE;
      DIV_IT:                   if (fin) nxt = DIV_FIX;
      default:                  nxt = IDLE;
    endcase
  end
  always_comb begin
    sub = op == OP_SUB;
    bx = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    ptop = prod[2*WIDTH-1:WIDTH-1];
    res_n = '0;
    c_n = 1'b0;
    o_n = 1'b0;
    if (state == EXEC) begin
      res_n[WIDTH-1:0] = sum[WIDTH-1:0];
      c_n = sum[WIDTH];
      o_n = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (state == MUL_IT) begin
      res_n = prod;
      o_n = !(&ptop || ~|ptop);
    end else if (state == DIV_FIX) begin
      res_n = prod;
    end else if (state == DONE_DIV0) begin
      res_n[REM_HALF*WIDTH +: WIDTH] = a;
      res_n[QUO_HALF*WIDTH +: WIDTH] = '1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      op            <= '0;
      a             <= '0;
      b             <= '0;
      cnt           <= '0;
      alu_result    <= '0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      flag_zero     <= 1'b0;
      flag_div0     <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        op  <= op_code;
        a   <= operand_A;
        b   <= operand_B;
        cnt <= CW'(WIDTH);
      end else if (mul_step || div_step) begin
        cnt <= cnt - 1'b1;
      end
      if (nxt == DONE) begin
        alu_result    <= res_n;
        flag_carry    <= c_n;
        flag_overflow <= o_n;
        flag_zero     <= res_n == '0;
        flag_div0     <= state == DONE_DIV0;
      end
    end
  end
  assign busy = state != IDLE;
  assign alu_done = state == DONE;
endmodule
